vend_controller: RTL and testbench

Sequencing controller for the vending machine. Accumulates inserted coins into a 13-bit balance and latches an item selection. It compares the item price against the balance, issues a one-cycle dispense pulse, then returns change, or a full refund on cancel. It sits between the coin/keypad front end and the dispenser/change-return actuators. The item price comes from a fixed price table.

---
 rtl/vend_pkg.sv | 34 +++
 rtl/vend_if.sv | 34 +++
 rtl/price_table.sv | 24 ++
 rtl/vend_controller.sv | 167 ++++++++++++++++
 tb/tb_vend_controller.sv | 306 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/vend_pkg.sv
// Shared definitions for the vending controller: money width, item count,
// FSM state codes and the fixed price list.
package vend_pkg;

  localparam int WIDTH     = 13;
  localparam int NUM_ITEMS = 8;
  // Selection index is one bit wider than needed for the items so that
  // out-of-range requests (8..15) can be seen and flagged.
  localparam int SEL_W     = 4;
  localparam int ITEM_W    = 3;

  typedef logic [WIDTH-1:0]  money_t;
  typedef logic [SEL_W-1:0]  sel_t;
  typedef logic [ITEM_W-1:0] item_t;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    COLLECT  = 3'd1,
    CHECK    = 3'd2,
    DISPENSE = 3'd3,
    CHANGE   = 3'd4
  } state_t;

  localparam money_t PRICES [NUM_ITEMS] = '{
    13'd100, 13'd125, 13'd150, 13'd175,
    13'd200, 13'd250, 13'd300, 13'd500
  };

  // True when a keypad index names a real item.
  function automatic logic sel_in_range(sel_t idx);
    return idx < SEL_W'(NUM_ITEMS);
  endfunction

endpackage

// File: rtl/vend_if.sv
// Bundle of front-end inputs and actuator outputs of the vending controller.
// master = coin/keypad front end and actuators, slave = the controller.
interface vend_if;
  import vend_pkg::*;

  logic   coin_valid;
  money_t coin_value;
  logic   sel_valid;
  sel_t   sel_item;
  logic   cancel;

  money_t balance;
  logic   dispense;
  item_t  dispense_item;
  logic   change_valid;
  money_t change_amount;
  logic   coin_reject;
  logic   err_short;
  logic   err_invalid;
  logic   busy;

  modport master (
    output coin_valid, coin_value, sel_valid, sel_item, cancel,
    input  balance, dispense, dispense_item, change_valid, change_amount,
           coin_reject, err_short, err_invalid, busy
  );

  modport slave (
    input  coin_valid, coin_value, sel_valid, sel_item, cancel,
    output balance, dispense, dispense_item, change_valid, change_amount,
           coin_reject, err_short, err_invalid, busy
  );

endinterface

// File: rtl/price_table.sv
// Combinational item-index to price lookup; out-of-range indices give 0.
module price_table
  import vend_pkg::*;
(
  input  sel_t   idx,
  output money_t price
);

  money_t masked [NUM_ITEMS];

  genvar gi;
  for (gi = 0; gi < NUM_ITEMS; gi++) begin : g_entry
    assign masked[gi] = (idx == SEL_W'(gi)) ? PRICES[gi] : '0;
  end

  // At most one entry is non-zero, so OR-ing them selects the match.
  always_comb begin
    price = '0;
    for (int i = 0; i < NUM_ITEMS; i++) begin
      price = price | masked[i];
    end
  end

endmodule

// File: rtl/vend_controller.sv
// Vending sequencer: credits coins, latches a selection, checks funds,
// pulses dispense and then returns change (or a full refund on cancel).
// Every output is a register loaded from the next-state logic.
module vend_controller
  import vend_pkg::*;
(
  input  logic clk,
  input  logic rst,
  vend_if.slave bus
);

  state_t state_reg, state_next;
  money_t balance_reg, balance_next;
  money_t price_reg, price_next;
  item_t  item_reg, item_next;

  logic   dispense_reg, dispense_next;
  item_t  dispense_item_reg, dispense_item_next;
  logic   change_valid_reg, change_valid_next;
  money_t change_amount_reg, change_amount_next;
  logic   coin_reject_reg, coin_reject_next;
  logic   err_short_reg, err_short_next;
  logic   err_invalid_reg, err_invalid_next;
  logic   busy_reg, busy_next;

  money_t           lookup_price;
  logic [WIDTH:0]   coin_sum;
  money_t           credit_bal;

  price_table u_price_table (
    .idx   (bus.sel_item),
    .price (lookup_price)
  );

  // One extra bit so a sum above the largest balance is detected, not wrapped.
  assign coin_sum = {1'b0, balance_reg} + {1'b0, bus.coin_value};

  // Next-state and next-output decode; pulses default low, data holds.
  always_comb begin
    state_next         = state_reg;
    balance_next       = balance_reg;
    price_next         = price_reg;
    item_next          = item_reg;
    dispense_item_next = dispense_item_reg;
    change_amount_next = change_amount_reg;
    coin_reject_next   = 1'b0;
    err_short_next     = 1'b0;
    err_invalid_next   = 1'b0;
    credit_bal         = balance_reg;

    case (state_reg)
      IDLE, COLLECT: begin
        // Coin is credited first so cancel/select see the updated balance.
        if (bus.coin_valid) begin
          if (coin_sum[WIDTH]) begin
            coin_reject_next = 1'b1;
          end else begin
            credit_bal = coin_sum[WIDTH-1:0];
          end
        end
        balance_next = credit_bal;

        if (bus.cancel && state_reg == COLLECT) begin
          change_amount_next = credit_bal;
          state_next         = CHANGE;
        end else if (bus.sel_valid) begin
          if (credit_bal == '0) begin
            err_short_next = 1'b1;
            state_next     = IDLE;
          end else if (!sel_in_range(bus.sel_item)) begin
            err_invalid_next = 1'b1;
            state_next       = COLLECT;
          end else begin
            item_next  = bus.sel_item[ITEM_W-1:0];
            price_next = lookup_price;
            state_next = CHECK;
          end
        end else begin
          state_next = (credit_bal == '0) ? IDLE : COLLECT;
        end
      end

      CHECK: begin
        coin_reject_next = bus.coin_valid;
        // Equal price and balance is enough to vend.
        if (price_reg <= balance_reg) begin
          balance_next       = balance_reg - price_reg;
          dispense_item_next = item_reg;
          state_next         = DISPENSE;
        end else begin
          err_short_next = 1'b1;
          state_next     = COLLECT;
        end
      end

      DISPENSE: begin
        coin_reject_next = bus.coin_valid;
        if (balance_reg != '0) begin
          change_amount_next = balance_reg;
          state_next         = CHANGE;
        end else begin
          state_next = IDLE;
        end
      end

      CHANGE: begin
        coin_reject_next = bus.coin_valid;
        balance_next     = '0;
        state_next       = IDLE;
      end

      default: begin
        balance_next = '0;
        state_next   = IDLE;
      end
    endcase

    // State-derived outputs are taken from the state being entered so the
    // registered value lines up with the cycle spent in that state.
    dispense_next     = (state_next == DISPENSE);
    change_valid_next = (state_next == CHANGE);
    busy_next         = (state_next == CHECK) || (state_next == DISPENSE) ||
                        (state_next == CHANGE);
  end

  // State and output registers; reset abandons any transaction in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg         <= IDLE;
      balance_reg       <= '0;
      price_reg         <= '0;
      item_reg          <= '0;
      dispense_reg      <= 1'b0;
      dispense_item_reg <= '0;
      change_valid_reg  <= 1'b0;
      change_amount_reg <= '0;
      coin_reject_reg   <= 1'b0;
      err_short_reg     <= 1'b0;
      err_invalid_reg   <= 1'b0;
      busy_reg          <= 1'b0;
    end else begin
      state_reg         <= state_next;
      balance_reg       <= balance_next;
      price_reg         <= price_next;
      item_reg          <= item_next;
      dispense_reg      <= dispense_next;
      dispense_item_reg <= dispense_item_next;
      change_valid_reg  <= change_valid_next;
      change_amount_reg <= change_amount_next;
      coin_reject_reg   <= coin_reject_next;
      err_short_reg     <= err_short_next;
      err_invalid_reg   <= err_invalid_next;
      busy_reg          <= busy_next;
    end
  end

  assign bus.balance       = balance_reg;
  assign bus.dispense      = dispense_reg;
  assign bus.dispense_item = dispense_item_reg;
  assign bus.change_valid  = change_valid_reg;
  assign bus.change_amount = change_amount_reg;
  assign bus.coin_reject   = coin_reject_reg;
  assign bus.err_short     = err_short_reg;
  assign bus.err_invalid   = err_invalid_reg;
  assign bus.busy          = busy_reg;

endmodule

// File: tb/tb_vend_controller.sv
// Bench for vend_controller: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a transaction model.
module tb_vend_controller;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  vend_if bus ();

  vend_controller dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    int bal;
    bit disp;
    int item;
    bit chg;
    int amt;
    bit rej;
    bit short_e;
    bit inv;
    bit busy;
  } exp_t;

  int   price_tab [8] = '{100, 125, 150, 175, 200, 250, 300, 500};
  int   coin_tab  [10] = '{0, 5, 10, 25, 50, 100, 500, 1000, 4000, 8000};

  exp_t exp_now;
  exp_t pend [$];
  int   m_bal;
  bit   cur_busy;
  bit   check_en;
  int   errors;
  int   checks;

  function automatic exp_t idle_exp(int b);
    exp_t e;
    e.bal = b; e.disp = 0; e.item = 0; e.chg = 0; e.amt = 0;
    e.rej = 0; e.short_e = 0; e.inv = 0; e.busy = 0;
    return e;
  endfunction

  task automatic chk(string name, int act, int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  // Transaction-level model: when a selection or cancel is accepted, the
  // whole outcome (check, dispense, change) is scheduled into a queue of
  // future-cycle expectations; while busy, coins only earn a reject.
  task automatic model_step(bit r, bit cv, int cval, bit sv, int si, bit cn);
    exp_t e;
    exp_t f;
    int nb;
    int rem;
    if (r) begin
      pend.delete();
      m_bal = 0;
      e = idle_exp(0);
    end else if (cur_busy) begin
      if (pend.size() > 0) e = pend.pop_front();
      else e = idle_exp(m_bal);
      if (cv) e.rej = 1;
    end else begin
      nb = m_bal;
      e = idle_exp(0);
      if (cv) begin
        if (m_bal + cval > 8191) e.rej = 1;
        else nb = m_bal + cval;
      end
      e.bal = nb;
      if (cn && m_bal != 0) begin
        e.chg = 1; e.amt = nb; e.busy = 1;
        m_bal = 0;
      end else if (sv) begin
        if (nb == 0) begin
          e.short_e = 1;
          m_bal = 0;
        end else if (si >= 8) begin
          e.inv = 1;
          m_bal = nb;
        end else begin
          e.busy = 1;
          if (price_tab[si] <= nb) begin
            rem = nb - price_tab[si];
            f = idle_exp(rem); f.disp = 1; f.item = si; f.busy = 1;
            pend.push_back(f);
            if (rem > 0) begin
              f = idle_exp(rem); f.chg = 1; f.amt = rem; f.busy = 1;
              pend.push_back(f);
            end
            m_bal = 0;
          end else begin
            f = idle_exp(nb); f.short_e = 1;
            pend.push_back(f);
            m_bal = nb;
          end
        end
      end else begin
        m_bal = nb;
      end
    end
    cur_busy = e.busy;
    exp_now  = e;
  endtask

  // Drive one cycle of inputs, advance the model on the edge, then settle.
  task automatic cycle(bit r, bit cv, int cval, bit sv, int si, bit cn);
    @(negedge clk);
    rst            = r;
    bus.coin_valid = cv;
    bus.coin_value = 13'(cval);
    bus.sel_valid  = sv;
    bus.sel_item   = 4'(si);
    bus.cancel     = cn;
    @(posedge clk);
    model_step(r, cv, cval, sv, si, cn);
    #1;
  endtask

  task automatic idle();
    cycle(0, 0, 0, 0, 0, 0);
  endtask

  task automatic coin(int v);
    cycle(0, 1, v, 0, 0, 0);
  endtask

  task automatic sel(int i);
    cycle(0, 0, 0, 1, i, 0);
  endtask

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (check_en) begin
      chk("balance", int'(bus.balance), exp_now.bal);
      chk("dispense", int'(bus.dispense), int'(exp_now.disp));
      if (exp_now.disp) chk("dispense_item", int'(bus.dispense_item), exp_now.item);
      chk("change_valid", int'(bus.change_valid), int'(exp_now.chg));
      if (exp_now.chg) chk("change_amount", int'(bus.change_amount), exp_now.amt);
      chk("coin_reject", int'(bus.coin_reject), int'(exp_now.rej));
      chk("err_short", int'(bus.err_short), int'(exp_now.short_e));
      chk("err_invalid", int'(bus.err_invalid), int'(exp_now.inv));
      chk("busy", int'(bus.busy), int'(exp_now.busy));
    end
  end

  initial begin
    errors = 0;
    checks = 0;
    check_en = 0;
    m_bal = 0;
    cur_busy = 0;
    exp_now = idle_exp(0);
    rst = 1'b1;
    bus.coin_valid = 1'b0;
    bus.coin_value = '0;
    bus.sel_valid  = 1'b0;
    bus.sel_item   = '0;
    bus.cancel     = 1'b0;
    @(posedge clk);
    #1;
    cycle(1, 0, 0, 0, 0, 0);
    check_en = 1;

    // Reset state
    chk("rst_balance", int'(bus.balance), 0);
    chk("rst_change_amount", int'(bus.change_amount), 0);
    chk("rst_dispense_item", int'(bus.dispense_item), 0);
    chk("rst_busy", int'(bus.busy), 0);
    $display("txn reset: balance=%0d busy=%0d", bus.balance, bus.busy);

    // Selection with no money
    sel(3);
    chk("idle_sel_short", int'(bus.err_short), 1);
    coin(0);
    chk("zero_coin_balance", int'(bus.balance), 0);
    $display("txn idle select/zero coin done");

    // Exact pay
    coin(100); coin(50);
    chk("exact_bal", int'(bus.balance), 150);
    sel(2);
    chk("exact_busy", int'(bus.busy), 1);
    idle();
    chk("exact_disp", int'(bus.dispense), 1);
    chk("exact_item", int'(bus.dispense_item), 2);
    chk("exact_bal0", int'(bus.balance), 0);
    idle();
    chk("exact_nochg", int'(bus.change_valid), 0);
    chk("exact_notbusy", int'(bus.busy), 0);
    $display("txn exact pay item 2");

    // Overpay
    coin(500); coin(25); sel(1); idle();
    chk("over_disp", int'(bus.dispense), 1);
    idle();
    chk("over_chg", int'(bus.change_valid), 1);
    chk("over_amt", int'(bus.change_amount), 400);
    idle();
    chk("over_bal0", int'(bus.balance), 0);
    $display("txn overpay item 1 change 400");

    // Short, then top up and reselect
    coin(100); sel(7); idle();
    chk("short_err", int'(bus.err_short), 1);
    chk("short_bal", int'(bus.balance), 100);
    coin(400);
    chk("short_topup", int'(bus.balance), 500);
    sel(7); idle();
    chk("short_disp", int'(bus.dispense), 1);
    idle();
    chk("short_nochg", int'(bus.change_valid), 0);
    $display("txn short then exact item 7");

    // Cancel with coin in the same cycle
    coin(50); coin(25);
    cycle(0, 1, 25, 0, 0, 1);
    chk("cancel_chg", int'(bus.change_valid), 1);
    chk("cancel_amt", int'(bus.change_amount), 100);
    idle();
    chk("cancel_bal0", int'(bus.balance), 0);
    $display("txn cancel+coin refund 100");

    // Overflow reject and top boundary
    coin(4000); coin(4000); coin(100);
    coin(100);
    chk("ovf_reject", int'(bus.coin_reject), 1);
    chk("ovf_bal", int'(bus.balance), 8100);
    coin(91);
    chk("max_bal", int'(bus.balance), 8191);
    chk("max_noreject", int'(bus.coin_reject), 0);
    cycle(0, 0, 0, 0, 0, 1);
    chk("max_refund", int'(bus.change_amount), 8191);
    idle();
    $display("txn overflow reject, refund 8191");

    // Coin + selection together, then coin during CHECK
    cycle(0, 1, 150, 1, 2, 0);
    idle();
    chk("coinsel_disp", int'(bus.dispense), 1);
    idle();
    coin(200); sel(0);
    coin(25);
    chk("check_disp", int'(bus.dispense), 1);
    chk("check_reject", int'(bus.coin_reject), 1);
    idle();
    chk("check_chg", int'(bus.change_amount), 100);
    idle();
    $display("txn coin during CHECK rejected");

    // Invalid index, then cancel beating an invalid index
    coin(100); sel(8);
    chk("inv_err", int'(bus.err_invalid), 1);
    chk("inv_busy", int'(bus.busy), 0);
    cycle(0, 0, 0, 1, 9, 1);
    chk("inv_cancel_chg", int'(bus.change_valid), 1);
    chk("inv_cancel_noerr", int'(bus.err_invalid), 0);
    idle();
    $display("txn invalid select and cancel");

    // Reset during DISPENSE
    coin(200); sel(0); idle();
    chk("rstd_disp", int'(bus.dispense), 1);
    cycle(1, 0, 0, 0, 0, 0);
    chk("rstd_nochg", int'(bus.change_valid), 0);
    chk("rstd_bal", int'(bus.balance), 0);
    chk("rstd_disp0", int'(bus.dispense), 0);
    idle();
    chk("rstd_nochg2", int'(bus.change_valid), 0);
    $display("txn reset during dispense");

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      bit r, cv, sv, cn;
      int cval, si;
      r    = ($urandom_range(0, 299) == 0);
      cv   = ($urandom_range(0, 2) == 0);
      cval = coin_tab[$urandom_range(0, 9)];
      sv   = ($urandom_range(0, 5) == 0);
      si   = $urandom_range(0, 9);
      cn   = ($urandom_range(0, 15) == 0);
      cycle(r, cv, cval, sv, si, cn);
      if (bus.dispense || bus.change_valid)
        $display("txn rnd %0d: disp=%0d item=%0d chg=%0d amt=%0d bal=%0d",
                 n, bus.dispense, bus.dispense_item, bus.change_valid,
                 bus.change_amount, bus.balance);
    end

    idle();
    @(negedge clk);
    #1;
    check_en = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
